// File: rtl/fdct_pkg.sv
// rtl/fdct_pkg.sv - shared types and constants for the FDCT butterfly stage
package fdct_pkg;

  typedef logic signed [7:0] sample_t;
  typedef logic signed [8:0] wide_t;

  localparam int ROW_LEN = 8;

  typedef enum logic {
    LOAD,
    EMIT
  } bs_state_t;

endpackage

// File: rtl/fdct_addsub.sv
// rtl/fdct_addsub.sv - sign-extending adder/subtractor for one butterfly pair
module fdct_addsub
  import fdct_pkg::*;
(
  input  sample_t i_a,
  input  sample_t i_b,
  input  logic    i_sub,
  output wide_t   o_res
);

  wide_t w_a;
  wide_t w_b;

  // Widen both operands by one sign bit so the full result range fits without wrap.
  assign w_a = {i_a[7], i_a};
  assign w_b = {i_b[7], i_b};

  // Sum or difference selected by i_sub; no saturation, the 9-bit range always holds.
  always_comb begin
    o_res = '0;
    if (i_sub) begin
      o_res = w_a - w_b;
    end else begin
      o_res = w_a + w_b;
    end
  end

endmodule

// File: rtl/fdct_butterfly_stage.sv
// rtl/fdct_butterfly_stage.sv - row buffer plus serial butterfly sums and differences
module fdct_butterfly_stage #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 9,
  parameter int ROW_LEN   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_IN-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_OUT-1:0] out_data,
  output logic [2:0]           out_index,
  output logic                 out_last
);

  import fdct_pkg::*;

  localparam logic [2:0] LAST_IDX = 3'(ROW_LEN - 1);

  sample_t    r_buf [ROW_LEN];
  bs_state_t  r_state;
  logic [2:0] r_cnt;

  sample_t w_a;
  sample_t w_b;
  logic    w_sub;
  wide_t   w_res;

  // Index k pairs x[k&3] with x[7-(k&3)]; bit 2 of k selects difference over sum.
  assign w_a   = r_buf[{1'b0, r_cnt[1:0]}];
  assign w_b   = r_buf[{1'b1, ~r_cnt[1:0]}];
  assign w_sub = r_cnt[2];

  fdct_addsub u_addsub (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_sub (w_sub),
    .o_res (w_res)
  );

  // Outputs decode only registered state, so stalls hold them and inputs never leak through.
  assign in_ready  = (r_state == LOAD);
  assign out_valid = (r_state == EMIT);
  assign out_data  = (r_state == EMIT) ? w_res : '0;
  assign out_index = (r_state == EMIT) ? r_cnt : 3'd0;
  assign out_last  = (r_state == EMIT) && (r_cnt == LAST_IDX);

  // Load a full row, then stream the eight results; a reset discards any partial work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LOAD;
      r_cnt   <= 3'd0;
      for (int i = 0; i < ROW_LEN; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      case (r_state)
        LOAD: begin
          if (in_valid) begin
            r_buf[r_cnt] <= in_data;
            if (r_cnt == LAST_IDX) begin
              r_cnt   <= 3'd0;
              r_state <= EMIT;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (r_cnt == LAST_IDX) begin
              r_cnt   <= 3'd0;
              r_state <= LOAD;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        default: begin
          r_state <= LOAD;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fdct_butterfly_stage.sv
// tb/tb_fdct_butterfly_stage.sv - scoreboard bench for the FDCT butterfly stage
module tb_fdct_butterfly_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic [2:0] out_index;
  logic       out_last;

  int n_checks = 0;
  int n_fail   = 0;
  int n_hs     = 0;
  int cyc      = 0;
  int low_cnt  = 0;

  typedef struct packed {
    logic [8:0] d;
    logic [2:0] k;
    logic       last;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;

  fdct_butterfly_stage #(
    .WIDTH_IN  (8),
    .WIDTH_OUT (9),
    .ROW_LEN   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (!reset && !in_ready) low_cnt++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every handshake pops the oldest expected result and compares it.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_hs++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got k=%0d data=%0d, expected no output", out_index, $signed(out_data));
      end else begin
        m_e = sb.pop_front();
        check("out_data",  int'($signed(out_data)), int'($signed(m_e.d)));
        check("out_index", int'(out_index), int'(m_e.k));
        check("out_last",  int'(out_last),  int'(m_e.last));
      end
    end
  end

  task automatic expect_row(input int e[8]);
    exp_t x;
    for (int k = 0; k < 8; k++) begin
      x.d    = 9'(e[k]);
      x.k    = 3'(k);
      x.last = (k == 7);
      sb.push_back(x);
    end
  endtask

  // Drives n samples; gapped inserts idle cycles with X data; hold keeps in_valid high afterwards.
  task automatic load_row(input int x[8], input int n, input bit gapped, input bit hold,
                          output int first_cyc);
    int  i = 0;
    int  t = 0;
    bit  acc;
    first_cyc = -1;
    while (i < n && t < 200) begin
      if (gapped && (t % 2 == 1)) begin
        in_valid = 1'b0;
        in_data  = 'x;
      end else begin
        in_valid = 1'b1;
        in_data  = 8'(x[i]);
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        if (i == 0) first_cyc = cyc;
        i++;
      end
      t++;
    end
    check("load_accepted", i, n);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      if (out_valid && out_last) in_valid = 1'b0;
      @(posedge clk);
      #1;
      t++;
    end
    check({name, "_pending"}, sb.size(), 0);
    sb.delete();
  endtask

  int row_a[8]   = '{1, 2, 3, 4, 5, 6, 7, 8};
  int exp_a[8]   = '{9, 9, 9, 9, -7, -5, -3, -1};
  int row_x[8]   = '{127, 127, 127, 127, -128, -128, -128, -128};
  int exp_x[8]   = '{-1, -1, -1, -1, 255, 255, 255, 255};
  int row_n[8]   = '{-128, -128, -128, -128, -128, -128, -128, -128};
  int exp_n[8]   = '{-256, -256, -256, -256, 0, 0, 0, 0};
  int row_b[8]   = '{10, 20, 30, 40, 50, 60, 70, 80};
  int exp_b[8]   = '{90, 90, 90, 90, -70, -50, -30, -10};
  int row_j[8]   = '{-5, 99, -100, 3, 7, -1, 50, 127};

  initial begin
    int c0;
    int c1;
    int hs0;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  int'(in_ready),  1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data",  int'(out_data),  0);
    check("rst_out_index", int'(out_index), 0);
    check("rst_out_last",  int'(out_last),  0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic row, in_ready low exactly eight cycles.
    low_cnt = 0;
    hs0 = n_hs;
    expect_row(exp_a);
    load_row(row_a, 8, 1'b0, 1'b0, c0);
    drain("basic");
    repeat (2) @(posedge clk);
    #1;
    check("basic_in_ready_low_cycles", low_cnt, 8);
    check("basic_handshakes", n_hs - hs0, 8);

    // Extremes.
    expect_row(exp_x);
    load_row(row_x, 8, 1'b0, 1'b0, c0);
    drain("extreme_mixed");
    expect_row(exp_n);
    load_row(row_n, 8, 1'b0, 1'b0, c0);
    drain("extreme_neg");

    // Backpressure at k=2 for five cycles.
    hs0 = n_hs;
    expect_row(exp_a);
    load_row(row_a, 8, 1'b0, 1'b0, c0);
    for (int t = 0; t < 20 && !(out_valid && out_index == 3'd2); t++) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk);
      #1;
      check("stall_data",  int'($signed(out_data)), 9);
      check("stall_index", int'(out_index), 2);
      check("stall_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    drain("stall");
    check("stall_handshakes", n_hs - hs0, 8);

    // Gapped input with X during idle, in_valid held high through EMIT.
    hs0 = n_hs;
    expect_row(exp_a);
    load_row(row_a, 8, 1'b1, 1'b1, c0);
    drain("gapped");
    check("gapped_handshakes", n_hs - hs0, 8);
    @(posedge clk);
    #1;
    check("gapped_back_to_load", int'(in_ready), 1);

    // Reset after five samples, then a fresh row.
    load_row(row_j, 5, 1'b0, 1'b0, c0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_in_ready",  int'(in_ready),  1);
    check("midrst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_row(exp_b);
    load_row(row_b, 8, 1'b0, 1'b0, c0);
    drain("after_reset");

    // Back-to-back rows with upstream always offering data.
    @(posedge clk);
    #1;
    hs0 = n_hs;
    expect_row(exp_a);
    expect_row(exp_b);
    load_row(row_a, 8, 1'b0, 1'b1, c0);
    load_row(row_b, 8, 1'b0, 1'b1, c1);
    drain("b2b");
    check("b2b_row_period", c1 - c0, 16);
    check("b2b_handshakes", n_hs - hs0, 16);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
